// File: rtl/uart_line_monitor.sv
// uart_line_monitor: UART receiver feeding a line-oriented classifier and an
// output FIFO. The receiver synchronises rxd_i, finds the start bit, samples
// each bit at mid-bit and checks the stop bit. Each good byte then goes to the
// classifier, which handles ESC sequences and CR/LF and sets the line-end flag.
// The byte is then pushed into a ready/valid FIFO.
// Optional feature: define UART_MON_PARITY_EN to receive one even-parity bit
// after the data bits; otherwise parity_err_o is tied low.
module uart_line_monitor #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 128,
    parameter int MAX_LINE     = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rxd_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_BITS-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 end_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overflow_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_LINE + 1);

    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [1:0]            sync_vld_q, sync_vld_d;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  esc_q, esc_d;
    logic [LW-1:0]         line_q, line_d;
    logic                  end_q, end_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_BITS:0]    mem_q [FIFO_DEPTH];

    logic                  rxd_s, tick, byte_done;
    logic                  push, push_last, pop, full, wr_en;
    logic [7:0]            byte8;

    assign rxd_s = sync_q[1];
    assign tick  = (cnt_q == '0);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst_i) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            sync_vld_q  <= 2'b00;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_valid_q  <= 1'b0;
            esc_q       <= 1'b0;
            line_q      <= '0;
            end_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            sync_vld_q  <= sync_vld_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_valid_q  <= rx_valid_d;
            esc_q       <= esc_d;
            line_q      <= line_d;
            end_q       <= end_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Synchroniser; after reset, a start bit is accepted only once the real line has been seen high
    always_comb begin
        sync_d     = {sync_q[0], rxd_i};
        sync_vld_d = {sync_vld_q[0], 1'b1};
        armed_d    = armed_q | (sync_vld_q[1] & rxd_s);
    end

    // RX FSM next state, bit timer, bit index and shift register
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q != S_IDLE && state_q != S_WAIT_HIGH && !tick)
            cnt_d = cnt_q - CW'(1);
        case (state_q)
            S_IDLE: if (armed_q && !rxd_s) begin
                state_d = S_START;
                cnt_d   = HALF_BIT;
            end
            S_START: if (tick) begin
                state_d = rxd_s ? S_IDLE : S_DATA;
                cnt_d   = FULL_BIT;
                bit_d   = '0;
            end
            S_DATA: if (tick) begin
                shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                cnt_d   = FULL_BIT;
                bit_d   = bit_q + BW'(1);
                if (bit_q == LAST_BIT) begin
`ifdef UART_MON_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_MON_PARITY_EN
            S_PARITY: if (tick) begin
                cnt_d   = FULL_BIT;
                state_d = (rxd_s == ^shift_q) ? S_STOP : S_WAIT_HIGH;
            end
`else
            S_PARITY: state_d = S_IDLE;
`endif
            S_STOP: if (tick) state_d = rxd_s ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rxd_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RX FSM outputs: good-byte strobe and error pulses
    always_comb begin
        byte_done   = (state_q == S_STOP) && tick && rxd_s;
        frame_err_d = (state_q == S_STOP) && tick && !rxd_s;
        rx_valid_d  = byte_done;
    end

`ifdef UART_MON_PARITY_EN
    logic parity_err_q;

    // Parity error pulse register
    always_ff @(posedge clk_i) begin
        if (rst_i) parity_err_q <= 1'b0;
        else       parity_err_q <= (state_q == S_PARITY) && tick && (rxd_s != ^shift_q);
    end
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    // Classifier: ESC sequences, CR discard, LF and max-length line ends
    always_comb begin
        byte8     = 8'(shift_q);
        push      = 1'b0;
        push_last = 1'b0;
        esc_d     = esc_q;
        line_d    = line_q;
        end_d     = 1'b0;
        if (rx_valid_q) begin
            if (esc_q) begin
                esc_d = 1'b0;
                end_d = (byte8 == 8'h04);
            end else if (byte8 == 8'h1B) begin
                esc_d = 1'b1;
            end else if (byte8 == 8'h0A) begin
                push      = 1'b1;
                push_last = 1'b1;
                line_d    = '0;
            end else if (byte8 != 8'h0D) begin
                push = 1'b1;
                if (line_q == LW'(MAX_LINE - 1)) begin
                    push_last = 1'b1;
                    line_d    = '0;
                end else begin
                    line_d = line_q + LW'(1);
                end
            end
        end
    end

    // FIFO control: a pop frees room for a push in the same cycle
    always_comb begin
        pop        = out_valid_o && out_ready_i;
        full       = (count_q == (AW+1)'(FIFO_DEPTH));
        wr_en      = push && (!full || pop);
        overflow_d = overflow_q | (push && !wr_en);
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!wr_en && pop) count_d = count_q - (AW+1)'(1);
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; validity comes from count_q alone.
        if (wr_en) mem_q[wr_ptr_q] <= {push_last, shift_q};
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q][DATA_BITS-1:0] : '0;
    assign out_last_o  = out_valid_o ? mem_q[rd_ptr_q][DATA_BITS] : 1'b0;
    assign end_o       = end_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: doc/uart_line_monitor.md
UART_LINE_MONITOR -- requirements
Module: uart_line_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per UART bit (>=4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 128, meaning output FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_LINE, default 128, meaning bytes per line before a forced line end.
REQ-005 SHALL have one clock, clk_i, and reset rst_i; reset is synchronous and active-high.
REQ-006 Port clk_i  input  1  sole clock, rising edge.
REQ-007 Port rst_i  input  1  synchronous active-high reset.
REQ-008 Port rxd_i  input  1  asynchronous UART line, idle high.
REQ-009 Port out_valid_o  output  1  FIFO head valid.
REQ-010 Port out_ready_i  input  1  consumer accepts head.
REQ-011 Port out_data_o  output  DATA_BITS  head byte.
REQ-012 Port out_last_o  output  1  head byte ends a line.
REQ-013 Port end_o  output  1  one-cycle pulse on ESC,0x04 sequence.
REQ-014 Port frame_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-015 Port parity_err_o  output  1  one-cycle pulse on parity mismatch.
REQ-016 Port overflow_o  output  1  sticky: byte dropped because FIFO full.

Function
REQ-017 rxd_i SHALL pass through a 2-flop synchroniser reset to 1; all sampling uses its output.
REQ-018 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE: synchronised low -> START, bit counter loaded for CLKS_PER_BIT/2 clocks (mid-bit).
REQ-020 START at mid-bit: low -> DATA; high -> IDLE (glitch rejected, no error).
REQ-021 DATA: SHALL sample every CLKS_PER_BIT clocks, LSB first, DATA_BITS samples, then PARITY or STOP.
REQ-022 STOP sample high -> byte delivered to classifier, FSM -> IDLE; low -> frame_err_o pulse, byte dropped, -> WAIT_HIGH.
REQ-023 WAIT_HIGH SHALL return to IDLE only after synchronised line reads high.
REQ-024 Classifier (control codes compared zero-extended): 0x1B sets esc flag, not stored.
REQ-025 With esc set: 0x04 -> end_o pulse; any byte clears esc and is discarded.
REQ-026 0x0D SHALL be discarded; 0x0A SHALL be stored with last=1 and reset line counter.
REQ-027 Other bytes stored with last=0, line counter +1; the byte making count==MAX_LINE gets last=1, counter -> 0.
REQ-028 Stored byte SHALL be written in the cycle after the stop sample; out_valid_o high one cycle after write.
REQ-029 Pop occurs when out_valid_o && out_ready_i; out_data_o/out_last_o SHALL hold while valid && !ready.
REQ-030 FIFO full: push dropped, overflow_o set, unless pop same cycle (then push accepted).
REQ-031 FIFO empty: out_valid_o low; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-032 On rst_i: FSM IDLE, esc clear, line counter 0, FIFO empty, all outputs 0, synchroniser 1.
REQ-033 rst_i mid-frame SHALL abandon the frame without error pulse; next start bit needs line high first.

Configuration
REQ-034 Macro UART_MON_PARITY_EN defined: PARITY state samples one even-parity bit; mismatch -> parity_err_o pulse, byte dropped, -> WAIT_HIGH.
REQ-035 Macro undefined: PARITY state absent, DATA -> STOP directly, parity_err_o tied 0.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4, MAX_LINE=3, ready=1 unless stated)
REQ-036 Send 'H','i',0x0A -> pops 0x48/last0, 0x69/last0, 0x0A/last1.
REQ-037 Send 0x0D,0x1B,0x41,0x1B,0x04 -> no pops; end_o single pulse after final stop bit.
REQ-038 Send 'a','b','c','d' -> 'c' popped with last=1, 'd' last=0.
REQ-039 ready=0, send 5 bytes 0x31..0x35 -> 4 held, overflow_o=1; ready=1 drains 0x31..0x34 in order.
REQ-040 Frame 0x55 with stop forced low -> frame_err_o pulse, no push; 8-clock low glitch -> nothing.
REQ-041 PARITY_EN: 0x07 with parity bit 0 -> parity_err_o pulse, no push; parity 1 -> 0x07 popped.
